// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad emulator and the keypad scanner:
// FSM state encoding, key-position fields and the idle column value.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BOUNCE  = 2'd1,
        HOLD    = 2'd2,
        RELEASE = 2'd3
    } kp_state_t;

    localparam int KEY_ROW_MSB = 3;
    localparam int KEY_ROW_LSB = 2;
    localparam int KEY_COL_MSB = 1;
    localparam int KEY_COL_LSB = 0;

    localparam logic [3:0] COL_IDLE = 4'b1111;

    function automatic logic [1:0] key_row(input logic [3:0] key);
        return key[KEY_ROW_MSB:KEY_ROW_LSB];
    endfunction

    function automatic logic [1:0] key_col(input logic [3:0] key);
        return key[KEY_COL_MSB:KEY_COL_LSB];
    endfunction

endpackage

// File: rtl/keypad_col_drive.sv
// Combinational column return: pulls the key's column low when its row is
// the single strobed row and the contact is closed; flags multi-row strobes.
module keypad_col_drive
    import keypad_pkg::*;
(
    input  logic       contact,
    input  logic [3:0] keypad_row,
    input  logic [1:0] row_sel,
    input  logic [1:0] col_sel,
    output logic [3:0] keypad_col,
    output logic       row_hit,
    output logic       multi_row
);

    logic [2:0] low_count;

    always_comb begin
        low_count = 3'd0;
        for (int i = 0; i < 4; i++) begin
            low_count = low_count + {2'b00, ~keypad_row[i]};
        end
        multi_row  = (low_count >= 3'd2);
        row_hit    = (low_count == 3'd1) && !keypad_row[row_sel];
        keypad_col = COL_IDLE;
        if (contact && row_hit) begin
            keypad_col[col_sel] = 1'b0;
        end
    end

endmodule

// File: rtl/keypad_emulator.sv
// Keypad responder: accepts a key-press request and plays out bounce, hold
// and release on the column lines, reporting completion and hold-time hits.
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int unsigned BOUNCE_PERIOD  = 4,
    parameter int unsigned BOUNCE_TOGGLES = 4,
    parameter int unsigned HOLD_CYCLES    = 3000000,
    parameter int unsigned RELEASE_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] keypad_row,
    output logic [3:0] keypad_col,
    input  logic       req_valid,
    input  logic [3:0] req_key,
    output logic       req_ready,
    input  logic       abort,
    output logic       done,
    output logic       aborted,
    output logic [7:0] scan_hits,
    output logic       protocol_err
);

    localparam logic [31:0] PERIOD_LAST  = 32'(BOUNCE_PERIOD - 1);
    localparam logic [31:0] TOGGLES_LAST = 32'(BOUNCE_TOGGLES - 1);
    localparam logic [31:0] HOLD_LAST    = 32'(HOLD_CYCLES - 1);
    localparam logic [31:0] RELEASE_LAST = 32'(RELEASE_CYCLES - 1);

    kp_state_t   state;
    logic        contact;
    logic [31:0] cnt;
    logic [31:0] toggle_cnt;
    logic [3:0]  key_q;
    logic [3:0]  prev_row;
    logic [1:0]  row_sel;
    logic [1:0]  col_sel;
    logic        row_hit;
    logic        multi_row;

    assign row_sel = key_row(key_q);
    assign col_sel = key_col(key_q);

    keypad_col_drive u_col_drive (
        .contact    (contact),
        .keypad_row (keypad_row),
        .row_sel    (row_sel),
        .col_sel    (col_sel),
        .keypad_col (keypad_col),
        .row_hit    (row_hit),
        .multi_row  (multi_row)
    );

    // One counter serves every timed state; it restarts on each state entry.
    // An abort always lands in RELEASE with a fresh count, so the scanner
    // sees a full open gap before the next press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            contact      <= 1'b0;
            cnt          <= 32'd0;
            toggle_cnt   <= 32'd0;
            key_q        <= 4'd0;
            prev_row     <= 4'b1111;
            req_ready    <= 1'b1;
            done         <= 1'b0;
            aborted      <= 1'b0;
            scan_hits    <= 8'd0;
            protocol_err <= 1'b0;
        end else begin
            done     <= 1'b0;
            prev_row <= keypad_row;
            if (contact && multi_row) begin
                protocol_err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        key_q      <= req_key;
                        contact    <= 1'b1;
                        req_ready  <= 1'b0;
                        scan_hits  <= 8'd0;
                        aborted    <= 1'b0;
                        cnt        <= 32'd0;
                        toggle_cnt <= 32'd0;
                        state      <= (BOUNCE_TOGGLES == 0) ? HOLD : BOUNCE;
                    end
                end
                BOUNCE: begin
                    if (abort) begin
                        contact <= 1'b0;
                        aborted <= 1'b1;
                        cnt     <= 32'd0;
                        state   <= RELEASE;
                    end else if (cnt == PERIOD_LAST) begin
                        cnt        <= 32'd0;
                        toggle_cnt <= toggle_cnt + 32'd1;
                        if (toggle_cnt == TOGGLES_LAST) begin
                            contact <= 1'b1;
                            state   <= HOLD;
                        end else begin
                            contact <= ~contact;
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                HOLD: begin
                    // Count falling strobes of the key's row, not cycles held low.
                    if (row_hit && prev_row[row_sel] && (scan_hits != 8'hFF)) begin
                        scan_hits <= scan_hits + 8'd1;
                    end
                    if (abort) begin
                        contact <= 1'b0;
                        aborted <= 1'b1;
                        cnt     <= 32'd0;
                        state   <= RELEASE;
                    end else if (cnt == HOLD_LAST) begin
                        contact <= 1'b0;
                        cnt     <= 32'd0;
                        state   <= RELEASE;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                RELEASE: begin
                    if (cnt == RELEASE_LAST) begin
                        cnt       <= 32'd0;
                        done      <= 1'b1;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                default: begin
                    contact <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed bench for keypad_emulator: instance A has bounce enabled, instance B
// runs the minimal no-bounce timing.
module tb_keypad_emulator;

    logic       clk;
    logic       rst;

    logic [3:0] row_a, col_a, key_a;
    logic       valid_a, ready_a, abort_a, done_a, aborted_a, perr_a;
    logic [7:0] hits_a;

    logic [3:0] row_b, col_b, key_b;
    logic       valid_b, ready_b, abort_b, done_b, aborted_b, perr_b;
    logic [7:0] hits_b;

    int checks   = 0;
    int failures = 0;

    logic [3:0] rows [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    keypad_emulator #(
        .BOUNCE_PERIOD  (2),
        .BOUNCE_TOGGLES (4),
        .HOLD_CYCLES    (20),
        .RELEASE_CYCLES (5)
    ) u_dut_a (
        .clk          (clk),
        .rst          (rst),
        .keypad_row   (row_a),
        .keypad_col   (col_a),
        .req_valid    (valid_a),
        .req_key      (key_a),
        .req_ready    (ready_a),
        .abort        (abort_a),
        .done         (done_a),
        .aborted      (aborted_a),
        .scan_hits    (hits_a),
        .protocol_err (perr_a)
    );

    keypad_emulator #(
        .BOUNCE_PERIOD  (1),
        .BOUNCE_TOGGLES (0),
        .HOLD_CYCLES    (1),
        .RELEASE_CYCLES (1)
    ) u_dut_b (
        .clk          (clk),
        .rst          (rst),
        .keypad_row   (row_b),
        .keypad_col   (col_b),
        .req_valid    (valid_b),
        .req_key      (key_b),
        .req_ready    (ready_b),
        .abort        (abort_b),
        .done         (done_b),
        .aborted      (aborted_b),
        .scan_hits    (hits_b),
        .protocol_err (perr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1;
        row_a = 4'b1101; valid_a = 1'b0; key_a = 4'd0; abort_a = 1'b0;
        row_b = 4'b1111; valid_b = 1'b0; key_b = 4'd0; abort_b = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (col_a !== 4'b1111) begin failures++; $display("[TB] FAIL reset_col got=%b exp=1111", col_a); end
        checks++; if (ready_a !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready got=%b exp=1", ready_a); end
        checks++; if (done_a !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b exp=0", done_a); end
        checks++; if (aborted_a !== 1'b0) begin failures++; $display("[TB] FAIL reset_aborted got=%b exp=0", aborted_a); end
        checks++; if (hits_a !== 8'd0) begin failures++; $display("[TB] FAIL reset_hits got=%0d exp=0", hits_a); end
        checks++; if (perr_a !== 1'b0) begin failures++; $display("[TB] FAIL reset_perr got=%b exp=0", perr_a); end
        checks++; if (ready_b !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready_b got=%b exp=1", ready_b); end
        @(negedge clk);
        rst = 1'b0;
        row_a = 4'b1111;
    endtask

    task automatic test_bounce();
        logic       ce;
        logic [3:0] exp_col;
        @(negedge clk);
        valid_a = 1'b1; key_a = 4'b0110; row_a = 4'b1111;
        #1;
        checks++; if (ready_a !== 1'b1) begin failures++; $display("[TB] FAIL bounce_ready_pre got=%b exp=1", ready_a); end
        for (int k = 0; k <= 34; k++) begin
            @(negedge clk);
            valid_a = 1'b0;
            abort_a = (k == 30);
            ce = (k < 8) ? ((k % 4) < 2) : (k < 28);
            row_a = 4'b1101;
            #1;
            exp_col = ce ? 4'b1011 : 4'b1111;
            checks++; if (col_a !== exp_col) begin failures++; $display("[TB] FAIL bounce_contact k=%0d got=%b exp=%b", k, col_a, exp_col); end
            row_a = rows[k % 4];
            #1;
            exp_col = (ce && (k % 4) == 1) ? 4'b1011 : 4'b1111;
            checks++; if (col_a !== exp_col) begin failures++; $display("[TB] FAIL bounce_col k=%0d got=%b exp=%b", k, col_a, exp_col); end
            checks++; if (done_a !== (k == 33)) begin failures++; $display("[TB] FAIL bounce_done k=%0d got=%b exp=%b", k, done_a, (k == 33)); end
            checks++; if (ready_a !== (k >= 33)) begin failures++; $display("[TB] FAIL bounce_ready k=%0d got=%b exp=%b", k, ready_a, (k >= 33)); end
            if (k == 33) begin
                checks++; if (aborted_a !== 1'b0) begin failures++; $display("[TB] FAIL bounce_aborted got=%b exp=0", aborted_a); end
                checks++; if (hits_a !== 8'd5) begin failures++; $display("[TB] FAIL bounce_hits got=%0d exp=5", hits_a); end
            end
        end
        row_a = 4'b1111;
        abort_a = 1'b0;
    endtask

    task automatic test_no_bounce();
        logic [3:0] exp_col;
        @(negedge clk);
        valid_b = 1'b1; key_b = 4'b0110; row_b = 4'b1111;
        #1;
        checks++; if (ready_b !== 1'b1) begin failures++; $display("[TB] FAIL nb_ready_pre got=%b exp=1", ready_b); end
        for (int k = 0; k <= 3; k++) begin
            @(negedge clk);
            valid_b = 1'b0;
            row_b = 4'b1101;
            #1;
            exp_col = (k == 0) ? 4'b1011 : 4'b1111;
            checks++; if (col_b !== exp_col) begin failures++; $display("[TB] FAIL nb_contact k=%0d got=%b exp=%b", k, col_b, exp_col); end
            row_b = 4'b1111;
            #1;
            checks++; if (ready_b !== (k >= 2)) begin failures++; $display("[TB] FAIL nb_ready k=%0d got=%b exp=%b", k, ready_b, (k >= 2)); end
            checks++; if (done_b !== (k == 2)) begin failures++; $display("[TB] FAIL nb_done k=%0d got=%b exp=%b", k, done_b, (k == 2)); end
            if (k == 2) begin
                checks++; if (hits_b !== 8'd0) begin failures++; $display("[TB] FAIL nb_hits got=%0d exp=0", hits_b); end
                checks++; if (aborted_b !== 1'b0) begin failures++; $display("[TB] FAIL nb_aborted got=%b exp=0", aborted_b); end
            end
        end
    endtask

    task automatic test_abort();
        logic       ce;
        logic [3:0] exp_col;
        @(negedge clk);
        valid_a = 1'b1; key_a = 4'b0110; row_a = 4'b1111;
        for (int k = 0; k <= 17; k++) begin
            @(negedge clk);
            valid_a = 1'b0;
            abort_a = (k == 10);
            ce = (k < 8) ? ((k % 4) < 2) : (k < 11);
            row_a = 4'b1101;
            #1;
            exp_col = ce ? 4'b1011 : 4'b1111;
            checks++; if (col_a !== exp_col) begin failures++; $display("[TB] FAIL abort_contact k=%0d got=%b exp=%b", k, col_a, exp_col); end
            row_a = rows[k % 4];
            #1;
            checks++; if (done_a !== (k == 16)) begin failures++; $display("[TB] FAIL abort_done k=%0d got=%b exp=%b", k, done_a, (k == 16)); end
            if (k == 16) begin
                checks++; if (aborted_a !== 1'b1) begin failures++; $display("[TB] FAIL abort_flag got=%b exp=1", aborted_a); end
                checks++; if (hits_a !== 8'd1) begin failures++; $display("[TB] FAIL abort_hits got=%0d exp=1", hits_a); end
            end
        end
        row_a = 4'b1111;
        abort_a = 1'b0;
    endtask

    task automatic test_multi_row();
        @(negedge clk);
        valid_a = 1'b1; key_a = 4'b0110; row_a = 4'b1111;
        for (int k = 0; k <= 33; k++) begin
            @(negedge clk);
            valid_a = 1'b0;
            row_a = (k == 12) ? 4'b1100 : ((k == 13) ? 4'b1101 : 4'b1111);
            #1;
            if (k == 12) begin
                checks++; if (col_a !== 4'b1111) begin failures++; $display("[TB] FAIL multi_col got=%b exp=1111", col_a); end
                checks++; if (perr_a !== 1'b0) begin failures++; $display("[TB] FAIL multi_perr_before got=%b exp=0", perr_a); end
            end
            if (k == 13) begin
                checks++; if (col_a !== 4'b1011) begin failures++; $display("[TB] FAIL multi_col_after got=%b exp=1011", col_a); end
                checks++; if (perr_a !== 1'b1) begin failures++; $display("[TB] FAIL multi_perr_set got=%b exp=1", perr_a); end
            end
            if (k == 33) begin
                checks++; if (done_a !== 1'b1) begin failures++; $display("[TB] FAIL multi_done got=%b exp=1", done_a); end
                checks++; if (perr_a !== 1'b1) begin failures++; $display("[TB] FAIL multi_perr_sticky got=%b exp=1", perr_a); end
                checks++; if (hits_a !== 8'd0) begin failures++; $display("[TB] FAIL multi_hits got=%0d exp=0", hits_a); end
                checks++; if (aborted_a !== 1'b0) begin failures++; $display("[TB] FAIL multi_aborted got=%b exp=0", aborted_a); end
            end
        end
        row_a = 4'b1111;
    endtask

    task automatic test_back_to_back();
        logic       ce;
        logic [3:0] exp_col;
        @(negedge clk);
        valid_a = 1'b1; key_a = 4'b0110; row_a = 4'b1111;
        for (int k = 0; k <= 34; k++) begin
            @(negedge clk);
            if (k < 34) ce = (k < 8) ? ((k % 4) < 2) : (k < 28);
            else        ce = 1'b1;
            row_a = 4'b1101;
            #1;
            exp_col = ce ? 4'b1011 : 4'b1111;
            checks++; if (col_a !== exp_col) begin failures++; $display("[TB] FAIL b2b_contact k=%0d got=%b exp=%b", k, col_a, exp_col); end
            row_a = 4'b1111;
            #1;
            checks++; if (ready_a !== (k == 33)) begin failures++; $display("[TB] FAIL b2b_ready k=%0d got=%b exp=%b", k, ready_a, (k == 33)); end
            checks++; if (done_a !== (k == 33)) begin failures++; $display("[TB] FAIL b2b_done k=%0d got=%b exp=%b", k, done_a, (k == 33)); end
        end
    endtask

    task automatic test_reset_mid_press();
        @(negedge clk);
        valid_a = 1'b0;
        row_a = 4'b1101;
        #1;
        checks++; if (col_a !== 4'b1011) begin failures++; $display("[TB] FAIL rmp_pre_col got=%b exp=1011", col_a); end
        rst = 1'b1;
        #1;
        checks++; if (col_a !== 4'b1111) begin failures++; $display("[TB] FAIL rmp_col got=%b exp=1111", col_a); end
        checks++; if (ready_a !== 1'b1) begin failures++; $display("[TB] FAIL rmp_ready got=%b exp=1", ready_a); end
        @(negedge clk);
        rst = 1'b0;
        row_a = 4'b1111;
        #1;
        checks++; if (perr_a !== 1'b0) begin failures++; $display("[TB] FAIL rmp_perr got=%b exp=0", perr_a); end
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #1;
            checks++; if (done_a !== 1'b0) begin failures++; $display("[TB] FAIL rmp_done k=%0d got=%b exp=0", k, done_a); end
        end
        checks++; if (ready_a !== 1'b1) begin failures++; $display("[TB] FAIL rmp_ready_after got=%b exp=1", ready_a); end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_no_bounce();
        test_abort();
        test_multi_row();
        test_back_to_back();
        test_reset_mid_press();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
